// File: rtl/ca_life_engine_if.sv
// ca_life_engine_if
// Bundles the control and data signals between the switch-entry/display
// stages and the Life generation engine.
//   load, seed[63:0], start, steps[3:0]   : requester -> engine
//   grid[63:0], gen_count[7:0],
//   population[6:0], busy, done           : engine -> display
// master : the side that requests runs and observes results
// slave  : the engine itself
interface ca_life_engine_if;
  logic        load;
  logic [63:0] seed;
  logic        start;
  logic [3:0]  steps;
  logic [63:0] grid;
  logic [7:0]  gen_count;
  logic [6:0]  population;
  logic        busy;
  logic        done;

  modport master (
    output load, seed, start, steps,
    input  grid, gen_count, population, busy, done
  );

  modport slave (
    input  load, seed, start, steps,
    output grid, gen_count, population, busy, done
  );
endinterface

// File: rtl/ca_life_engine.sv
// ca_life_engine
// Runs Conway's Life (B3/S23) on a toroidal 8x8 board, one row per clock.
// The committed grid stays stable while the next generation is built in a
// shadow register, then all 64 cells are committed in a single cycle.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : ca_life_engine_if.slave (load/seed/start/steps in,
//           grid/gen_count/population/busy/done out, all registered)
module ca_life_engine (
  input logic             clk,
  input logic             reset,
  ca_life_engine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_r;
  logic [63:0] grid_r;
  logic [63:0] next_r;
  logic [6:0]  pop_r;
  logic [7:0]  gen_r;
  logic [3:0]  remaining_r;
  logic [2:0]  row_r;
  logic        busy_r;
  logic        done_r;
  logic [7:0]  next_row_s;

  // Number of live cells in a 64-bit grid word.
  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] s;
    s = 7'd0;
    for (int i = 0; i < 64; i++) begin
      s = s + {6'd0, v[i]};
    end
    return s;
  endfunction

  // Live neighbours of (r,c). The 3-bit row/column arithmetic wraps mod 8,
  // and {row,col} is directly the bit index row*8+col.
  function automatic logic [3:0] neighbours(input logic [63:0] g,
                                            input logic [2:0]  r,
                                            input logic [2:0]  c);
    logic [2:0] rm, rp, cm, cp;
    rm = r - 3'd1;
    rp = r + 3'd1;
    cm = c - 3'd1;
    cp = c + 3'd1;
    return {3'd0, g[{rm, cm}]} + {3'd0, g[{rm, c}]} + {3'd0, g[{rm, cp}]} +
           {3'd0, g[{r,  cm}]}                      + {3'd0, g[{r,  cp}]} +
           {3'd0, g[{rp, cm}]} + {3'd0, g[{rp, c}]} + {3'd0, g[{rp, cp}]};
  endfunction

  // Next-generation value of all eight cells in one row.
  function automatic logic [7:0] life_row(input logic [63:0] g,
                                          input logic [2:0]  r);
    logic [7:0] row;
    logic [3:0] n;
    row = 8'd0;
    for (int c = 0; c < 8; c++) begin
      n = neighbours(g, r, 3'(c));
      row[c] = (n == 4'd3) | (g[{r, 3'(c)}] & (n == 4'd2));
    end
    return row;
  endfunction

  // Row currently being evaluated from the committed grid.
  always_comb begin
    next_row_s = 8'd0;
    if (state_r == COMPUTE) begin
      next_row_s = life_row(grid_r, row_r);
    end else begin
      next_row_s = 8'd0;
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      grid_r      <= 64'd0;
      next_r      <= 64'd0;
      pop_r       <= 7'd0;
      gen_r       <= 8'd0;
      remaining_r <= 4'd0;
      row_r       <= 3'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          // load wins over start in the same cycle
          if (bus.load) begin
            grid_r <= bus.seed;
            pop_r  <= popcount64(bus.seed);
            gen_r  <= 8'd0;
          end else if (bus.start) begin
            if (bus.steps != 4'd0) begin
              remaining_r <= bus.steps;
              row_r       <= 3'd0;
              busy_r      <= 1'b1;
              state_r     <= COMPUTE;
            end else begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        COMPUTE: begin
          next_r[{row_r, 3'd0} +: 8] <= next_row_s;
          if (row_r == 3'd7) begin
            state_r <= COMMIT;
          end else begin
            row_r <= row_r + 3'd1;
          end
        end
        COMMIT: begin
          grid_r      <= next_r;
          pop_r       <= popcount64(next_r);
          gen_r       <= gen_r + 8'd1;
          remaining_r <= remaining_r - 4'd1;
          if (remaining_r == 4'd1) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            row_r   <= 3'd0;
            state_r <= COMPUTE;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.grid       = grid_r;
  assign bus.gen_count  = gen_r;
  assign bus.population = pop_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_ca_life_engine.sv
// tb_ca_life_engine
// Directed and randomized checks of ca_life_engine against a cell-by-cell
// Life reference model. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_ca_life_engine;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [63:0] exp_grid;
  logic [7:0]  exp_gen;

  ca_life_engine_if bus ();

  ca_life_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One generation of B3/S23 on a toroidal 8x8 board.
  function automatic logic [63:0] life_step(input logic [63:0] g);
    logic [63:0] nx;
    int n;
    nx = 64'd0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              n += int'(g[((r + dr + 8) % 8) * 8 + ((c + dc + 8) % 8)]);
            end
          end
        end
        nx[r * 8 + c] = (n == 3) || (g[r * 8 + c] && n == 2);
      end
    end
    return nx;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [63:0] s);
    @(negedge clk);
    bus.load = 1'b1;
    bus.seed = s;
    @(negedge clk);
    bus.load = 1'b0;
    exp_grid = s;
    exp_gen  = 8'd0;
    check("load_grid", bus.grid, s);
    check("load_pop", 64'(bus.population), 64'($countones(s)));
    check("load_gen", 64'(bus.gen_count), 64'd0);
    check("load_busy", 64'(bus.busy), 64'd0);
  endtask

  // Runs n generations; optionally pokes load/start while busy.
  task automatic do_run(input int n, input bit disturb);
    logic [63:0] gens[$];
    int busy_cnt;
    int done_at;
    int g;
    gens.push_back(exp_grid);
    for (int i = 1; i <= n; i++) gens.push_back(life_step(gens[i - 1]));
    busy_cnt = 0;
    done_at  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.steps = 4'(n);
    for (int k = 1; k <= 200 && done_at == 0; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (disturb && k == 3) begin
        bus.load  = 1'b1;
        bus.start = 1'b1;
        bus.seed  = {$urandom, $urandom};
      end else begin
        bus.load = 1'b0;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) done_at = k;
      g = (k - 1) / 9;
      if (g > n) g = n;
      check("run_grid_cycle", bus.grid, gens[g]);
    end
    bus.load  = 1'b0;
    bus.start = 1'b0;
    exp_grid  = gens[n];
    exp_gen   = exp_gen + 8'(n);
    check("run_done_cycle", 64'(done_at), 64'((n == 0) ? 1 : 9 * n + 1));
    check("run_busy_cycles", 64'(busy_cnt), 64'(9 * n));
    check("run_grid", bus.grid, exp_grid);
    check("run_pop", 64'(bus.population), 64'($countones(exp_grid)));
    check("run_gen", 64'(bus.gen_count), 64'(exp_gen));
    @(negedge clk);
    check("run_done_pulse_end", 64'(bus.done), 64'd0);
    check("run_busy_end", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int   saw_done;
    int   saw_busy;
    logic [63:0] s;
    checks    = 0;
    failures  = 0;
    exp_grid  = 64'd0;
    exp_gen   = 8'd0;
    bus.load  = 1'b0;
    bus.seed  = 64'd0;
    bus.start = 1'b0;
    bus.steps = 4'd0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_grid", bus.grid, 64'd0);
    check("rst_pop", 64'(bus.population), 64'd0);
    check("rst_gen", 64'(bus.gen_count), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    reset = 1'b0;

    // Blinker, one and two generations
    do_load(64'h0000_0000_0000_0E00);
    do_run(1, 1'b0);
    check("blinker1_grid", bus.grid, 64'h0000_0000_0004_0404);
    check("blinker1_pop", 64'(bus.population), 64'd3);
    check("blinker1_gen", 64'(bus.gen_count), 64'd1);
    do_load(64'h0000_0000_0000_0E00);
    do_run(2, 1'b0);
    check("blinker2_grid", bus.grid, 64'h0000_0000_0000_0E00);
    check("blinker2_gen", 64'(bus.gen_count), 64'd2);

    // Still life and torus wrap
    do_load(64'h0303);
    do_run(15, 1'b0);
    check("block_grid", bus.grid, 64'h0303);
    check("block_pop", 64'(bus.population), 64'd4);
    check("block_gen", 64'(bus.gen_count), 64'd15);
    do_load(64'h83);
    do_run(1, 1'b0);
    check("edge_blinker", bus.grid, 64'h0100_0000_0000_0101);

    // All ones dies out
    do_load({64{1'b1}});
    do_run(1, 1'b0);
    check("allones_grid", bus.grid, 64'd0);
    check("allones_pop", 64'(bus.population), 64'd0);

    // steps=0: done only
    do_load({$urandom, $urandom});
    do_run(0, 1'b0);

    // load and start together: load only
    s = {$urandom, $urandom};
    @(negedge clk);
    bus.load  = 1'b1;
    bus.start = 1'b1;
    bus.steps = 4'd5;
    bus.seed  = s;
    @(negedge clk);
    bus.load  = 1'b0;
    bus.start = 1'b0;
    exp_grid  = s;
    exp_gen   = 8'd0;
    check("ldst_grid", bus.grid, s);
    check("ldst_busy", 64'(bus.busy), 64'd0);
    check("ldst_gen", 64'(bus.gen_count), 64'd0);
    @(negedge clk);
    check("ldst_busy2", 64'(bus.busy), 64'd0);
    check("ldst_done2", 64'(bus.done), 64'd0);

    // load/start while busy are ignored
    do_run(3, 1'b1);

    // Randomized seeds and lengths
    for (int i = 0; i < 6; i++) begin
      do_load({$urandom, $urandom});
      do_run(int'($urandom_range(1, 4)), 1'b0);
    end

    // gen_count wrap 255 -> 0
    do_load(64'h0303);
    for (int i = 0; i < 17; i++) do_run(15, 1'b0);
    check("wrap_gen255", 64'(bus.gen_count), 64'd255);
    do_run(1, 1'b0);
    check("wrap_gen0", 64'(bus.gen_count), 64'd0);

    // Reset in the middle of COMPUTE
    do_load(64'h0000_0000_0000_0E00);
    @(negedge clk);
    bus.start = 1'b1;
    bus.steps = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_grid", bus.grid, 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_gen", 64'(bus.gen_count), 64'd0);
    check("midrst_pop", 64'(bus.population), 64'd0);
    reset    = 1'b0;
    saw_done = 0;
    saw_busy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done++;
      if (bus.busy === 1'b1) saw_busy++;
    end
    check("midrst_no_done", 64'(saw_done), 64'd0);
    check("midrst_no_busy", 64'(saw_busy), 64'd0);
    check("midrst_grid_after", bus.grid, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
